// File: rtl/game_timer.sv
// game_timer
//   Level countdown timer and one-second timebase for the game flow
//   controller. A free-running prescaler produces one_sec_pulse. While a
//   level is active (game_on) the count of seconds runs down from
//   START_SECONDS. When it reaches 0:00, timer_ended is raised. The count is
//   also presented as registered BCD digits for the HUD.
//
//   Optional feature: define GAME_TIMER_WARN_EN to build the low-time blink
//   on `warn`. When the macro is undefined, `warn` is tied low.
//
// Parameters
//   CLK_FREQ       clock cycles per second
//   START_SECONDS  per-level load value, 1..599
//   BONUS_SECONDS  seconds added per bonus_add pulse
//   WARN_SECONDS   low-time threshold (only used with GAME_TIMER_WARN_EN)
//
// Ports
//   clk            system clock
//   resetN         asynchronous, active-low reset
//   game_on        level active
//   freeze         holds the countdown; the prescaler keeps running
//   bonus_add      single-cycle pickup pulse; a held level adds every cycle
//   one_sec_pulse  one-cycle pulse every CLK_FREQ cycles
//   timer_ended    countdown reached 0:00; held until game_on falls
//   minutes        BCD minutes 0..9
//   sec_tens       BCD seconds tens 0..5
//   sec_ones       BCD seconds ones 0..9
//   warn           low-time blink
//   dbg_state_o    current FSM state (0 idle, 1 run, 2 expired)
module game_timer #(
   parameter int CLK_FREQ      = 31_500_000,
   parameter int START_SECONDS = 180,
   parameter int BONUS_SECONDS = 10,
   parameter int WARN_SECONDS  = 30
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       game_on,
   input  logic       freeze,
   input  logic       bonus_add,
   output logic       one_sec_pulse,
   output logic       timer_ended,
   output logic [3:0] minutes,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       warn,
   output logic [1:0] dbg_state_o
);

   localparam int            PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_FREQ - 1);
   localparam logic [10:0]   MAX_SECS  = 11'd599;
   localparam logic [9:0]    START_S   = 10'(START_SECONDS);
   localparam logic [10:0]   BONUS_S   = 11'((BONUS_SECONDS > 599) ? 599 : BONUS_SECONDS);
   localparam logic [3:0]    START_MIN = 4'(START_SECONDS / 60);
   localparam logic [3:0]    START_TEN = 4'((START_SECONDS % 60) / 10);
   localparam logic [3:0]    START_ONE = 4'(START_SECONDS % 10);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q;
   logic          pulse_q;
   logic          gon_q, gon_prev_q;
   logic [9:0]    secs_q, secs_d;
   logic          ended_q;
   logic [3:0]    min_q, ten_q, one_q;
   logic          tick, rise;
   logic [10:0]   nxt;

   // Prescaler: free-running, independent of the FSM and of freeze.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pre_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= (pre_q == PRE_MAX);
         pre_q   <= (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
      end
   end

   // game_on is registered before the rising-edge compare, so the load
   // lands one edge after game_on is first sampled high.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         gon_q      <= 1'b0;
         gon_prev_q <= 1'b0;
      end else begin
         gon_q      <= game_on;
         gon_prev_q <= gon_q;
      end
   end

   assign tick = pulse_q & ~freeze;
   assign rise = gon_q & ~gon_prev_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         secs_q  <= START_S;
         ended_q <= 1'b0;
      end else begin
         state_q <= state_d;
         secs_q  <= secs_d;
         ended_q <= (state_d == ST_EXPIRED);
      end
   end

   // Bonus and decrement are applied to one widened value, so a bonus on
   // the final pulse rescues the level instead of expiring it.
   always_comb begin
      state_d = state_q;
      secs_d  = secs_q;
      nxt     = {1'b0, secs_q};
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               secs_d  = START_S;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!game_on) begin
               state_d = ST_IDLE;
            end else if (tick || bonus_add) begin
               if (bonus_add) nxt = nxt + BONUS_S;
               if (tick && (nxt != 11'd0)) nxt = nxt - 11'd1;
               if (nxt > MAX_SECS) nxt = MAX_SECS;
               secs_d = nxt[9:0];
               if (nxt == 11'd0) state_d = ST_EXPIRED;
            end
         end
         ST_EXPIRED: begin
            secs_d = 10'd0;
            if (!game_on) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered BCD digits, one cycle behind secs_q.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         min_q <= START_MIN;
         ten_q <= START_TEN;
         one_q <= START_ONE;
      end else begin
         min_q <= 4'(secs_q / 10'd60);
         ten_q <= 4'((secs_q % 10'd60) / 10'd10);
         one_q <= 4'(secs_q % 10'd10);
      end
   end

`ifdef GAME_TIMER_WARN_EN
   localparam logic [9:0] WARN_S = 10'((WARN_SECONDS > 599) ? 599 : WARN_SECONDS);

   logic win_d, win_q, warn_q;

   // Window is judged on next-state values so warn drops on the same edge
   // the count leaves the window or the timer expires.
   assign win_d = (state_d == ST_RUN) && (secs_d != 10'd0) && (secs_d <= WARN_S);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         win_q  <= 1'b0;
         warn_q <= 1'b0;
      end else begin
         win_q <= win_d;
         if (!win_d)       warn_q <= 1'b0;
         else if (!win_q)  warn_q <= 1'b1;
         else if (pulse_q) warn_q <= ~warn_q;
      end
   end

   assign warn = warn_q;
`else
   assign warn = 1'b0;
`endif

   assign one_sec_pulse = pulse_q;
   assign timer_ended   = ended_q;
   assign minutes       = min_q;
   assign sec_tens      = ten_q;
   assign sec_ones      = one_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with CLK_FREQ=10, START_SECONDS=3,
// BONUS_SECONDS=2, WARN_SECONDS=2, plus a second instance loaded at 598 to
// exercise saturation. Expected output snapshots are queued by the stimulus
// and compared by a negedge monitor.
module tb_game_timer;

`ifdef GAME_TIMER_WARN_EN
   localparam bit WARN_ON = 1'b1;
`else
   localparam bit WARN_ON = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_EXP  = 2'd2;
   localparam int         W      = 18;

   // clock / reset
   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   // cycles since reset release, counted on rising edges
   int cyc;
   always @(posedge clk or negedge resetN) begin
      if (!resetN) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   logic game_on = 1'b0, freeze = 1'b0, bonus_add = 1'b0;
   logic game_on_b = 1'b0, freeze_b = 1'b0, bonus_b = 1'b0;

   logic       pulse_a, ended_a, warn_a;
   logic [3:0] min_a, ten_a, one_a;
   logic [1:0] st_a;
   logic       pulse_b, ended_b, warn_b;
   logic [3:0] min_b, ten_b, one_b;
   logic [1:0] st_b;

   game_timer #(.CLK_FREQ(10), .START_SECONDS(3), .BONUS_SECONDS(2), .WARN_SECONDS(2)) dut (
      .clk(clk), .resetN(resetN), .game_on(game_on), .freeze(freeze), .bonus_add(bonus_add),
      .one_sec_pulse(pulse_a), .timer_ended(ended_a), .minutes(min_a), .sec_tens(ten_a),
      .sec_ones(one_a), .warn(warn_a), .dbg_state_o(st_a)
   );

   game_timer #(.CLK_FREQ(10), .START_SECONDS(598), .BONUS_SECONDS(2), .WARN_SECONDS(2)) dut_sat (
      .clk(clk), .resetN(resetN), .game_on(game_on_b), .freeze(freeze_b), .bonus_add(bonus_b),
      .one_sec_pulse(pulse_b), .timer_ended(ended_b), .minutes(min_b), .sec_tens(ten_b),
      .sec_ones(one_b), .warn(warn_b), .dbg_state_o(st_b)
   );

   // scoreboard: {sel, state, pulse, ended, warn, min, tens, ones}
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   task automatic chk(input string nm, input bit sel, input logic [1:0] st, input bit p,
                      input bit e, input bit w, input logic [3:0] m, input logic [3:0] t,
                      input logic [3:0] o);
      exp_q.push_back({sel, st, p, e, w & WARN_ON, m, t, o});
      name_q.push_back(nm);
   endtask

   // monitor
   initial begin
      logic [W-1:0] exp_v, obs_v;
      string        nm;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            if (exp_v[W-1])
               obs_v = {1'b1, st_b, pulse_b, ended_b, warn_b, min_b, ten_b, one_b};
            else
               obs_v = {1'b0, st_a, pulse_a, ended_a, warn_a, min_a, ten_a, one_a};
            n_checks++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL %s @cyc %0d: got st=%0d p=%b e=%b w=%b %0d/%0d/%0d, expected st=%0d p=%b e=%b w=%b %0d/%0d/%0d",
                        nm, cyc, obs_v[16:15], obs_v[14], obs_v[13], obs_v[12], obs_v[11:8], obs_v[7:4], obs_v[3:0],
                        exp_v[16:15], exp_v[14], exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
         end
      end
   end

   // driver: advance to 1 time unit after the rising edge that makes cyc == n
   task automatic to_cycle(input int n);
      int budget = 0;
      while (cyc != n) begin
         if (budget > 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL to_cycle: cyc %0d, wanted %0d", cyc, n);
            return;
         end
         @(posedge clk);
         #1;
         budget++;
      end
   endtask

   initial begin
      @(posedge clk); #1;
      chk("reset_a", 1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd3);
      chk("reset_b", 1'b1, S_IDLE, 0, 0, 0, 4'd9, 4'd5, 4'd8);
      @(posedge clk); #1;
      resetN = 1'b1;

      // timebase on A while B exercises saturation
      for (int c = 1; c <= 35; c++) begin
         to_cycle(c);
         case (c)
            1:  game_on_b = 1'b1;
            3:  bonus_b   = 1'b1;
            4:  bonus_b   = 1'b0;
            20: bonus_b   = 1'b1;
            21: bonus_b   = 1'b0;
            default: ;
         endcase
         chk("timebase", 1'b0, S_IDLE, (c % 10 == 0), 0, 0, 4'd0, 4'd0, 4'd3);
         case (c)
            2:  chk("sat_idle",       1'b1, S_IDLE, 0, 0, 0, 4'd9, 4'd5, 4'd8);
            3:  chk("sat_load",       1'b1, S_RUN,  0, 0, 0, 4'd9, 4'd5, 4'd8);
            5:  chk("sat_bonus",      1'b1, S_RUN,  0, 0, 0, 4'd9, 4'd5, 4'd9);
            12: chk("sat_tick",       1'b1, S_RUN,  0, 0, 0, 4'd9, 4'd5, 4'd8);
            22: chk("sat_bonus_tick", 1'b1, S_RUN,  0, 0, 0, 4'd9, 4'd5, 4'd9);
            default: ;
         endcase
      end

      // basic expiry
      game_on = 1'b1;
      to_cycle(36);  chk("edge_delay",   1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(37);  chk("load_run",     1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(40);  chk("pulse_40",     1'b0, S_RUN,  1, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(41);  chk("warn_enter",   1'b0, S_RUN,  0, 0, 1, 4'd0, 4'd0, 4'd3);
      to_cycle(42);  chk("count_2",      1'b0, S_RUN,  0, 0, 1, 4'd0, 4'd0, 4'd2);
      to_cycle(52);  chk("count_1",      1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd1);
      to_cycle(61);  chk("expire_edge",  1'b0, S_EXP,  0, 1, 0, 4'd0, 4'd0, 4'd1);
      to_cycle(62);  chk("expire_digits",1'b0, S_EXP,  0, 1, 0, 4'd0, 4'd0, 4'd0);
      to_cycle(112); chk("expired_hold", 1'b0, S_EXP,  0, 1, 0, 4'd0, 4'd0, 4'd0);
      game_on = 1'b0;
      to_cycle(113); chk("ended_clear",  1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd0);

      // freeze and bonus
      game_on = 1'b1;
      to_cycle(115); chk("reload_lag",   1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd0);
      to_cycle(116); chk("reload",       1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(121); freeze = 1'b1;
      to_cycle(122); chk("freeze_start", 1'b0, S_RUN,  0, 0, 1, 4'd0, 4'd0, 4'd2);
      to_cycle(132); chk("freeze_hold1", 1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd2);
      to_cycle(141); freeze = 1'b0;
      to_cycle(142); chk("freeze_hold2", 1'b0, S_RUN,  0, 0, 1, 4'd0, 4'd0, 4'd2);
      to_cycle(150); bonus_add = 1'b1;
      to_cycle(151); bonus_add = 1'b0;
      to_cycle(152); chk("bonus_tick",   1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(153); bonus_add = 1'b1;
      to_cycle(154); bonus_add = 1'b0;
      to_cycle(155); chk("bonus_only",   1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd5);
      to_cycle(192); chk("count_down_1", 1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd1);
      to_cycle(200); bonus_add = 1'b1;
      to_cycle(201); bonus_add = 1'b0;
      chk("bonus_saves",        1'b0, S_RUN, 0, 0, 1, 4'd0, 4'd0, 4'd1);
      to_cycle(202); chk("bonus_saves_digits", 1'b0, S_RUN, 0, 0, 1, 4'd0, 4'd0, 4'd2);

      // pause and reload
      game_on = 1'b0;
      to_cycle(203); chk("pause",        1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd2);
      to_cycle(222); chk("pause_hold",   1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd2);
      game_on = 1'b1;
      to_cycle(224); chk("resume_load",  1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd2);
      to_cycle(225); chk("resume_digits",1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd3);

      // reset mid-run at secs == 1
      to_cycle(242); chk("pre_reset",    1'b0, S_RUN,  0, 0, 0, 4'd0, 4'd0, 4'd1);
      to_cycle(243);
      resetN    = 1'b0;
      game_on   = 1'b0;
      game_on_b = 1'b0;
      chk("reset_async",     1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd3);
      chk("reset_async_sat", 1'b1, S_IDLE, 0, 0, 0, 4'd9, 4'd5, 4'd8);
      @(posedge clk);
      @(posedge clk); #1;
      resetN = 1'b1;
      to_cycle(9);  chk("post_reset_9",  1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(10); chk("post_reset_10", 1'b0, S_IDLE, 1, 0, 0, 4'd0, 4'd0, 4'd3);
      to_cycle(11); chk("post_reset_11", 1'b0, S_IDLE, 0, 0, 0, 4'd0, 4'd0, 4'd3);

      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
